// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: pipeline-age states and forwarding selects.
package hazard_pkg;

  // Age of the youngest in-flight writer of a register, counted in pipeline stages past ID.
  localparam logic [1:0] AGE_IDLE = 2'd0;
  localparam logic [1:0] AGE_EX   = 2'd1;
  localparam logic [1:0] AGE_MEM  = 2'd2;
  localparam logic [1:0] AGE_WB   = 2'd3;

  // Operand source selects driven to the ID/EX operand muxes.
  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  // One pipeline step: EX->MEM->WB, and a writer leaving WB retires to idle.
  function automatic logic [1:0] age_advance(input logic [1:0] age);
    logic [1:0] nxt;
    nxt = AGE_IDLE;
    case (age)
      AGE_EX:  nxt = AGE_MEM;
      AGE_MEM: nxt = AGE_WB;
      default: nxt = AGE_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Per-read-port hazard check: maps the producer age of one source register to a
// forwarding select and a stall request.
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter bit BR_EX_STALL = 1'b1
) (
  input  logic [1:0] i_age,
  input  logic       i_ld,
  input  logic       i_used,
  input  logic       i_is_br,
  input  logic       i_r0_mask,
  output logic [1:0] o_fwd_sel,
  output logic       o_port_stall
);

  logic w_active;

  assign w_active = i_used & ~i_r0_mask;

  // Decode producer age into forwarding path and stall request.
  always_comb begin
    o_fwd_sel    = FWD_REG;
    o_port_stall = 1'b0;
    if (w_active) begin
      unique case (i_age)
        AGE_IDLE: o_fwd_sel = FWD_REG;
        AGE_EX: begin
          // Load data is not ready until MEM; a branch in ID has no EX->ID path.
          o_fwd_sel    = FWD_EX;
          o_port_stall = i_ld | (i_is_br & BR_EX_STALL);
        end
        AGE_MEM: begin
          // Load data appears only at the end of MEM, too late for a branch compare in ID.
          o_fwd_sel    = FWD_MEM;
          o_port_stall = i_is_br & i_ld;
        end
        AGE_WB: o_fwd_sel = FWD_WB;
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard interlock/forwarding unit: tracks the youngest in-flight writer of each
// architectural register by pipeline age and derives forwarding selects, stall and PC hold.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned AW          = 3,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned R0_ZERO     = 0,
  parameter int unsigned BR_EX_STALL = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_issue_valid,
  input  logic                 i_issue_we,
  input  logic                 i_issue_load,
  input  logic [AW-1:0]        i_issue_dst,
  input  logic                 i_issue_br,
  input  logic [NUM_RD*AW-1:0] i_src_addr,
  input  logic [NUM_RD-1:0]    i_src_used,
  input  logic                 i_pipe_hold,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic                 o_pc_hold,
  output logic [NUM_RD*2-1:0]  o_fwd_sel,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  localparam int unsigned NUM_REGS = 1 << AW;

  logic [1:0]          r_age [NUM_REGS];
  logic [NUM_REGS-1:0] r_ld;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic [1:0]          w_age_d [NUM_REGS];
  logic [NUM_REGS-1:0] w_ld_d;
  logic [CNT_W-1:0]    w_stall_cnt_d;

  logic [NUM_RD-1:0]   w_port_stall;
  logic                w_stall;
  logic                w_dst_masked;
  logic                w_record;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [AW-1:0] w_src;
    logic          w_r0_mask;

    assign w_src     = i_src_addr[k*AW +: AW];
    assign w_r0_mask = (R0_ZERO != 0) && (w_src == '0);

    hazard_src_check #(
      .BR_EX_STALL(BR_EX_STALL != 0)
    ) u_src_check (
      .i_age       (r_age[w_src]),
      .i_ld        (r_ld[w_src]),
      .i_used      (i_src_used[k]),
      .i_is_br     (i_issue_br),
      .i_r0_mask   (w_r0_mask),
      .o_fwd_sel   (o_fwd_sel[k*2 +: 2]),
      .o_port_stall(w_port_stall[k])
    );
  end

  // A flushed ID instruction never stalls; an invalid one never stalls.
  assign w_stall   = i_issue_valid & ~i_flush & (|w_port_stall);
  assign o_stall   = w_stall;
  assign o_pc_hold = w_stall;

  assign w_dst_masked = (R0_ZERO != 0) && (i_issue_dst == '0);
  assign w_record     = i_issue_valid & i_issue_we & ~w_stall & ~i_flush & ~w_dst_masked;

  // Next scoreboard state: age every live entry, squash EX on flush, then record the ID writer.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_age_d[r] = r_age[r];
      w_ld_d[r]  = r_ld[r];
      if (!i_pipe_hold) begin
        if (i_flush && (r_age[r] == AGE_EX)) begin
          w_age_d[r] = AGE_IDLE;
        end else begin
          w_age_d[r] = age_advance(r_age[r]);
        end
        if (w_age_d[r] == AGE_IDLE) begin
          w_ld_d[r] = 1'b0;
        end
        // Youngest writer wins: an older in-flight writer of the same register is forgotten.
        if (w_record && (i_issue_dst == AW'(r))) begin
          w_age_d[r] = AGE_EX;
          w_ld_d[r]  = i_issue_load;
        end
      end
    end
  end

  // Saturating count of cycles the front end was held by an interlock.
  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (w_stall && !i_pipe_hold && !(&r_stall_cnt)) begin
      w_stall_cnt_d = r_stall_cnt + 1'b1;
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_age[r] <= AGE_IDLE;
      end
      r_ld <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_age[r] <= w_age_d[r];
      end
      r_ld <= w_ld_d;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_d;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (default config; R0 hardwired, no branch EX
// stall, 2-bit counter) share stimulus and are checked against a pipeline-slot model.
module tb_hazard_scoreboard;

  localparam int unsigned AW     = 3;
  localparam int unsigned NUM_RD = 2;

  logic clk;
  logic rst_n;
  logic issue_valid, issue_we, issue_load, issue_br, pipe_hold, flush;
  logic [AW-1:0]        issue_dst;
  logic [NUM_RD*AW-1:0] src_addr;
  logic [NUM_RD-1:0]    src_used;

  logic stall_a, pc_hold_a, stall_b, pc_hold_b;
  logic [NUM_RD*2-1:0] fwd_a, fwd_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard #(
    .AW(AW), .NUM_RD(NUM_RD), .R0_ZERO(0), .BR_EX_STALL(1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_issue_valid(issue_valid), .i_issue_we(issue_we),
    .i_issue_load(issue_load), .i_issue_dst(issue_dst), .i_issue_br(issue_br),
    .i_src_addr(src_addr), .i_src_used(src_used), .i_pipe_hold(pipe_hold), .i_flush(flush),
    .o_stall(stall_a), .o_pc_hold(pc_hold_a), .o_fwd_sel(fwd_a), .o_stall_cnt(cnt_a)
  );

  hazard_scoreboard #(
    .AW(AW), .NUM_RD(NUM_RD), .R0_ZERO(1), .BR_EX_STALL(0), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_issue_valid(issue_valid), .i_issue_we(issue_we),
    .i_issue_load(issue_load), .i_issue_dst(issue_dst), .i_issue_br(issue_br),
    .i_src_addr(src_addr), .i_src_used(src_used), .i_pipe_hold(pipe_hold), .i_flush(flush),
    .o_stall(stall_b), .o_pc_hold(pc_hold_b), .o_fwd_sel(fwd_b), .o_stall_cnt(cnt_b)
  );

  // Reference model: the instructions sitting in EX (0), MEM (1), WB (2) per instance.
  bit          m_we  [2][3];
  bit          m_ld  [2][3];
  logic [AW-1:0] m_dst [2][3];
  int          m_cnt [2];
  bit          cfg_r0z  [2] = '{1'b0, 1'b1};
  bit          cfg_brex [2] = '{1'b1, 1'b0};
  int          cfg_max  [2] = '{65535, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_eval(input int m, output logic st, output logic [3:0] fw);
    bit any;
    any = 1'b0;
    fw  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0] src;
      int stage;
      bit ld;
      src   = src_addr[k*AW +: AW];
      stage = 0;
      ld    = 1'b0;
      if (!src_used[k] || (cfg_r0z[m] && src == 0)) continue;
      // Scan oldest to youngest so the youngest matching writer is the one kept.
      for (int s = 2; s >= 0; s--) begin
        if (m_we[m][s] && m_dst[m][s] == src) begin
          stage = s + 1;
          ld    = m_ld[m][s];
        end
      end
      fw[2*k +: 2] = 2'(stage);
      if (stage == 1 && ld) any = 1'b1;
      if (issue_br && stage == 1 && !ld && cfg_brex[m]) any = 1'b1;
      if (issue_br && stage == 2 && ld) any = 1'b1;
    end
    st = issue_valid && !flush && any;
  endfunction

  function automatic void model_edge(input int m);
    logic st;
    logic [3:0] fw;
    bit rec;
    model_eval(m, st, fw);
    if (pipe_hold) return;
    if (st && m_cnt[m] < cfg_max[m]) m_cnt[m]++;
    m_we[m][2]  = m_we[m][1];
    m_ld[m][2]  = m_ld[m][1];
    m_dst[m][2] = m_dst[m][1];
    m_we[m][1]  = flush ? 1'b0 : m_we[m][0];
    m_ld[m][1]  = m_ld[m][0];
    m_dst[m][1] = m_dst[m][0];
    rec = issue_valid && issue_we && !st && !flush && !(cfg_r0z[m] && issue_dst == 0);
    if (rec) begin
      for (int s = 1; s < 3; s++)
        if (m_dst[m][s] == issue_dst) m_we[m][s] = 1'b0;
    end
    m_we[m][0]  = rec;
    m_ld[m][0]  = issue_load;
    m_dst[m][0] = issue_dst;
  endfunction

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0;
      for (int s = 0; s < 3; s++) begin
        m_we[m][s]  = 1'b0;
        m_ld[m][s]  = 1'b0;
        m_dst[m][s] = '0;
      end
    end
  endfunction

  task automatic check_all();
    logic es;
    logic [3:0] ef;
    model_eval(0, es, ef);
    chk("stall_a", stall_a, es);
    chk("pc_hold_a", pc_hold_a, es);
    chk("cnt_a", cnt_a, 32'(m_cnt[0]));
    if (!es) chk("fwd_a", fwd_a, ef);
    model_eval(1, es, ef);
    chk("stall_b", stall_b, es);
    chk("pc_hold_b", pc_hold_b, es);
    chk("cnt_b", cnt_b, 32'(m_cnt[1]));
    if (!es) chk("fwd_b", fwd_b, ef);
  endtask

  task automatic drive(input bit v, input bit we, input bit ld, input logic [AW-1:0] dst,
                       input bit br, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                       input logic [1:0] used, input bit hold, input bit fl);
    issue_valid = v;
    issue_we    = we;
    issue_load  = ld;
    issue_dst   = dst;
    issue_br    = br;
    src_addr    = {s1, s0};
    src_used    = used;
    pipe_hold   = hold;
    flush       = fl;
  endtask

  task automatic set_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // Outputs are sampled on the falling edge, state advances on the rising edge.
  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_idle();
    model_clear();
    #2;
    chk("rst_stall", stall_a, 0);
    chk("rst_pc_hold", pc_hold_a, 0);
    chk("rst_fwd", fwd_a, 0);
    chk("rst_cnt", cnt_a, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_clear();
    do_reset();

    // ALU chain on r1: forward from EX, MEM, WB, then regfile.
    drive(1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 0, 2'b01, 0, 0);
    settle(); chk("t1_fwd_ex", fwd_a[1:0], 2'b01); chk("t1_nostall", stall_a, 0); advance();
    settle(); chk("t1_fwd_mem", fwd_a[1:0], 2'b10); advance();
    settle(); chk("t1_fwd_wb", fwd_a[1:0], 2'b11); advance();
    settle(); chk("t1_fwd_reg", fwd_a[1:0], 2'b00); advance();

    // Load-use on port 1.
    do_reset();
    drive(1, 1, 1, 2, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 2, 2'b10, 0, 0);
    settle(); chk("t2_stall", stall_a, 1); chk("t2_pc_hold", pc_hold_a, 1); advance();
    settle(); chk("t2_fwd_mem", fwd_a[3:2], 2'b10); chk("t2_nostall", stall_a, 0);
    chk("t2_cnt", cnt_a, 1); advance();

    // Branch after ALU, then branch after load.
    do_reset();
    drive(1, 1, 0, 3, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 1, 3, 0, 2'b01, 0, 0);
    settle(); chk("t3_br_alu_stall", stall_a, 1); chk("t3_b_br_fwd_ex", fwd_b[1:0], 2'b01);
    advance();
    settle(); chk("t3_br_alu_fwd", fwd_a[1:0], 2'b10); chk("t3_br_go", stall_a, 0); advance();
    drive(1, 1, 1, 3, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 1, 3, 0, 2'b01, 0, 0);
    settle(); chk("t3_br_ld_stall1", stall_a, 1); advance();
    settle(); chk("t3_br_ld_stall2", stall_a, 1); advance();
    settle(); chk("t3_br_ld_fwd", fwd_a[1:0], 2'b11); chk("t3_br_ld_go", stall_a, 0);
    chk("t3_cnt", cnt_a, 3); advance();

    // Youngest writer wins; r0 hardwired only in instance b.
    do_reset();
    drive(1, 1, 1, 4, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 1, 0, 4, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 0, 4, 0, 2'b01, 0, 0);
    settle(); chk("t4_young_fwd", fwd_a[1:0], 2'b01); chk("t4_young_nostall", stall_a, 0);
    advance();
    drive(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
    settle(); chk("t4_r0_b", fwd_b[1:0], 2'b00); chk("t4_r0_a", fwd_a[1:0], 2'b01); advance();

    // Flush squashes the load in EX; pipe_hold freezes state and counter.
    do_reset();
    drive(1, 1, 1, 5, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 1, 0, 6, 0, 5, 0, 2'b01, 0, 1);
    settle(); chk("t5_flush_nostall", stall_a, 0); advance();
    drive(1, 0, 0, 0, 0, 5, 6, 2'b11, 0, 0);
    settle(); chk("t5_flushed_fwd", fwd_a, 4'b0000); chk("t5_flushed_nostall", stall_a, 0);
    advance();
    drive(1, 1, 1, 5, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 0, 5, 0, 2'b01, 1, 0);
    for (int i = 0; i < 3; i++) begin
      settle(); chk("t5_hold_stall", stall_a, 1); chk("t5_hold_cnt", cnt_a, 0); advance();
    end
    pipe_hold = 1'b0;
    settle(); chk("t5_release_stall", stall_a, 1); advance();
    settle(); chk("t5_release_fwd", fwd_a[1:0], 2'b10); chk("t5_cnt", cnt_a, 1); advance();

    // Counter saturation, then asynchronous reset in the middle of a stall.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 2, 0, 0, 0, 2'b00, 0, 0); step();
      drive(1, 0, 0, 0, 0, 2, 0, 2'b01, 0, 0); step(); step();
    end
    settle(); chk("t6_cnt_a", cnt_a, 5); chk("t6_cnt_b_sat", cnt_b, 3); advance();
    drive(1, 1, 1, 2, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 0, 2, 0, 2'b01, 0, 0);
    settle(); chk("t6_pre_stall", stall_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_stall", stall_a, 0);
    chk("t6_async_fwd", fwd_a, 0);
    chk("t6_async_cnt", cnt_a, 0);
    chk("t6_async_cnt_b", cnt_b, 0);
    model_clear();
    rst_n = 1'b1;
    set_idle();
    advance();
    drive(1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 0, 2'b01, 0, 0);
    settle(); chk("t6_after_rst_fwd", fwd_a[1:0], 2'b01); advance();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(9, 0) != 0, $urandom_range(1, 0) != 0, $urandom_range(2, 0) == 0,
            AW'($urandom), $urandom_range(3, 0) == 0, AW'($urandom), AW'($urandom),
            2'($urandom), $urandom_range(9, 0) == 0, $urandom_range(11, 0) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
